// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word-addressed SRAM responder for one imemory/dmemory initiator port
module mem_responder #(
    parameter int depth_log2 = 12,
    parameter int latency    = 1,
    parameter bit init_zero  = 1
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        memory_valid,
    input  logic        memory_instr,
    input  logic [31:0] memory_addr,
    input  logic [31:0] memory_wdata,
    input  logic [3:0]  memory_wstrb,
    output logic [31:0] memory_rdata,
    output logic        memory_ready
);

    localparam int         words  = 1 << depth_log2;
    localparam logic [3:0] reload = 4'(latency - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [3:0]              counter;
    logic [31:0]             resp_data;
    logic [31:0]             rd_word;
    logic [depth_log2-1:0]   idx;
    logic                    accept;
    logic                    wr_en;

    assign idx   = memory_addr[depth_log2+1:2];
    assign wr_en = accept && !rst && (memory_wstrb != 4'b0000);

    // Instruction flag and the ignored address bits are informational only.
    logic unused_bits;
    assign unused_bits = ^{memory_instr, memory_addr[31:depth_log2+2], memory_addr[1:0]};

    generate
        if (init_zero) begin : g_zero
            logic [31:0] mem [0:words-1] = '{default: '0};
            always_ff @(posedge clk) begin
                if (wr_en) begin
                    for (int i = 0; i < 4; i++) begin
                        if (memory_wstrb[i]) mem[idx][8*i +: 8] <= memory_wdata[8*i +: 8];
                    end
                end
            end
            assign rd_word = mem[idx];
        end else begin : g_raw
            logic [31:0] mem [0:words-1];
            always_ff @(posedge clk) begin
                if (wr_en) begin
                    for (int i = 0; i < 4; i++) begin
                        if (memory_wstrb[i]) mem[idx][8*i +: 8] <= memory_wdata[8*i +: 8];
                    end
                end
            end
            assign rd_word = mem[idx];
        end
    endgenerate

    // A new request may overlap the ready cycle, giving back-to-back responses.
    always_comb begin
        accept     = memory_valid && ((state == IDLE) || (counter == 4'd0));
        next_state = state;
        if (accept) begin
            next_state = BUSY;
        end else if ((state == BUSY) && (counter == 4'd0)) begin
            next_state = IDLE;
        end
        memory_ready = (state == BUSY) && (counter == 4'd0);
        memory_rdata = memory_ready ? resp_data : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            counter   <= 4'd0;
            resp_data <= 32'h0;
        end else begin
            state <= next_state;
            if (accept) begin
                counter   <= reload;
                resp_data <= (memory_wstrb != 4'b0000) ? 32'h0 : rd_word;
            end else if (counter != 4'd0) begin
                counter <= counter - 4'd1;
            end
        end
    end

endmodule
